id_ex_alu_stage: RTL and testbench

//  ID/EX pipeline register and ALU operand stage of the MIPS datapath; directly upstream of the 32-bit ALU.

---
 rtl/id_ex_alu_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_id_ex_alu_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register and ALU operand stage: latches decoded fields, derives the ALU opcode,
// extends the immediate and forwards operands. Optional macro ALU_FWD_EN enables EX/MEM and MEM/WB forwarding.
module id_ex_alu_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [15:0]           imm16,
    input  logic [5:0]            funct,
    input  logic [5:0]            i_opcode,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [1:0]            alu_op,
    input  logic                  alu_src,
    input  logic                  reg_dst,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  exmem_reg_write,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic [DATA_W-1:0]     mwb_result,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [3:0]            alu_opcode,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_check_ovf,
    output logic                  ex_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [3:0]            dec_opcode_s;
    logic                  dec_ovf_s;
    logic                  dec_illegal_s;
    logic                  dec_zext_s;
    logic [DATA_W-1:0]     imm_ext_s;

    logic                  valid_q,      valid_d;
    logic [DATA_W-1:0]     rs_data_q,    rs_data_d;
    logic [DATA_W-1:0]     rt_data_q,    rt_data_d;
    logic [DATA_W-1:0]     imm_q,        imm_d;
    logic [REG_ADDR_W-1:0] rs_addr_q,    rs_addr_d;
    logic [REG_ADDR_W-1:0] rt_addr_q,    rt_addr_d;
    logic [REG_ADDR_W-1:0] dest_q,       dest_d;
    logic [3:0]            opcode_q,     opcode_d;
    logic                  alu_src_q,    alu_src_d;
    logic                  reg_write_q,  reg_write_d;
    logic                  mem_read_q,   mem_read_d;
    logic                  mem_write_q,  mem_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  check_ovf_q,  check_ovf_d;
    logic                  illegal_q,    illegal_d;

    logic [DATA_W-1:0]     fwd_rs_s;
    logic [DATA_W-1:0]     fwd_rt_s;

    // Opcode, overflow-check, legality and extension-mode decode
    always_comb begin
        dec_opcode_s  = OP_ADD;
        dec_ovf_s     = 1'b0;
        dec_illegal_s = 1'b0;
        dec_zext_s    = 1'b0;
        case (alu_op)
            2'b00: dec_opcode_s = OP_ADD;
            2'b01: dec_opcode_s = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: begin dec_opcode_s = OP_ADD; dec_ovf_s = 1'b1; end
                    6'b100001: dec_opcode_s = OP_ADD;
                    6'b100010: begin dec_opcode_s = OP_SUB; dec_ovf_s = 1'b1; end
                    6'b100011: dec_opcode_s = OP_SUB;
                    6'b100100: dec_opcode_s = OP_AND;
                    6'b100101: dec_opcode_s = OP_OR;
                    6'b100111: dec_opcode_s = OP_NOR;
                    6'b101010: dec_opcode_s = OP_SLT;
                    default: begin dec_opcode_s = OP_ADD; dec_illegal_s = 1'b1; end
                endcase
            end
            2'b11: begin
                case (i_opcode)
                    6'b001000: begin dec_opcode_s = OP_ADD; dec_ovf_s = 1'b1; end
                    6'b001001: dec_opcode_s = OP_ADD;
                    6'b001010: dec_opcode_s = OP_SLT;
                    6'b001100: begin dec_opcode_s = OP_AND; dec_zext_s = 1'b1; end
                    6'b001101: begin dec_opcode_s = OP_OR;  dec_zext_s = 1'b1; end
                    default: begin dec_opcode_s = OP_ADD; dec_illegal_s = 1'b1; end
                endcase
            end
            default: dec_opcode_s = OP_ADD;
        endcase
    end

    // Logical immediates are zero-extended, everything else sign-extended
    always_comb begin
        if (dec_zext_s) begin
            imm_ext_s = {{(DATA_W-16){1'b0}}, imm16};
        end else begin
            imm_ext_s = {{(DATA_W-16){imm16[15]}}, imm16};
        end
    end

    // Next-state: flush beats stall; a non-valid load is a bubble like flush
    always_comb begin
        valid_d      = valid_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        dest_d       = dest_q;
        opcode_d     = opcode_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        check_ovf_d  = check_ovf_q;
        illegal_d    = illegal_q;
        if (flush || (!stall && !in_valid)) begin
            valid_d      = 1'b0;
            rs_data_d    = {DATA_W{1'b0}};
            rt_data_d    = {DATA_W{1'b0}};
            imm_d        = {DATA_W{1'b0}};
            rs_addr_d    = {REG_ADDR_W{1'b0}};
            rt_addr_d    = {REG_ADDR_W{1'b0}};
            dest_d       = {REG_ADDR_W{1'b0}};
            opcode_d     = 4'b0000;
            alu_src_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            check_ovf_d  = 1'b0;
            illegal_d    = 1'b0;
        end else if (!stall) begin
            valid_d      = 1'b1;
            rs_data_d    = rs_data;
            rt_data_d    = rt_data;
            imm_d        = imm_ext_s;
            rs_addr_d    = rs_addr;
            rt_addr_d    = rt_addr;
            dest_d       = reg_dst ? rd_addr : rt_addr;
            opcode_d     = dec_opcode_s;
            alu_src_d    = alu_src;
            reg_write_d  = reg_write & ~dec_illegal_s;
            mem_read_d   = mem_read;
            mem_write_d  = mem_write;
            mem_to_reg_d = mem_to_reg;
            check_ovf_d  = dec_ovf_s;
            illegal_d    = dec_illegal_s;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            rs_data_q    <= {DATA_W{1'b0}};
            rt_data_q    <= {DATA_W{1'b0}};
            imm_q        <= {DATA_W{1'b0}};
            rs_addr_q    <= {REG_ADDR_W{1'b0}};
            rt_addr_q    <= {REG_ADDR_W{1'b0}};
            dest_q       <= {REG_ADDR_W{1'b0}};
            opcode_q     <= 4'b0000;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            check_ovf_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            dest_q       <= dest_d;
            opcode_q     <= opcode_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            check_ovf_q  <= check_ovf_d;
            illegal_q    <= illegal_d;
        end
    end

`ifdef ALU_FWD_EN
    // Operand forwarding: the younger EX/MEM result wins, register 0 never forwards
    always_comb begin
        if (exmem_reg_write && (exmem_rd != {REG_ADDR_W{1'b0}}) && (exmem_rd == rs_addr_q)) begin
            fwd_rs_s = exmem_result;
        end else if (mwb_reg_write && (mwb_rd != {REG_ADDR_W{1'b0}}) && (mwb_rd == rs_addr_q)) begin
            fwd_rs_s = mwb_result;
        end else begin
            fwd_rs_s = rs_data_q;
        end
        if (exmem_reg_write && (exmem_rd != {REG_ADDR_W{1'b0}}) && (exmem_rd == rt_addr_q)) begin
            fwd_rt_s = exmem_result;
        end else if (mwb_reg_write && (mwb_rd != {REG_ADDR_W{1'b0}}) && (mwb_rd == rt_addr_q)) begin
            fwd_rt_s = mwb_result;
        end else begin
            fwd_rt_s = rt_data_q;
        end
    end
`else
    logic unused_fwd_s;

    // Without forwarding the hazard unit stalls, so registered data is used as-is
    always_comb begin
        fwd_rs_s = rs_data_q;
        fwd_rt_s = rt_data_q;
    end

    assign unused_fwd_s = ^{exmem_reg_write, mwb_reg_write, exmem_rd, mwb_rd,
                            exmem_result, mwb_result, rs_addr_q, rt_addr_q};
`endif

    assign alu_a         = fwd_rs_s;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt_s;
    assign ex_store_data = fwd_rt_s;
    assign alu_opcode    = opcode_q;
    assign ex_valid      = valid_q;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_check_ovf  = check_ovf_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage; expected stage state is pushed at each edge and popped for comparison.
module tb_id_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic [5:0]  funct, i_opcode;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [1:0]  alu_op;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic        exmem_reg_write, mwb_reg_write;
    logic [4:0]  exmem_rd, mwb_rd;
    logic [31:0] exmem_result, mwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_opcode;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_check_ovf, ex_illegal;
    logic [4:0]  ex_dest;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  opc;
        logic [4:0]  dest;
        logic [4:0]  rs_a;
        logic [4:0]  rt_a;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic        asrc;
        logic        rw, mr, mw, m2r, ovf, ill;
    } exp_t;

    exp_t model_r;
    exp_t sb_q[$];

    id_ex_alu_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16), .funct(funct),
        .i_opcode(i_opcode), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .mwb_reg_write(mwb_reg_write),
        .exmem_rd(exmem_rd), .mwb_rd(mwb_rd), .exmem_result(exmem_result),
        .mwb_result(mwb_result), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_check_ovf(ex_check_ovf), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Returns {zext, illegal, ovf, opcode[3:0]}
    function automatic logic [6:0] dec(input logic [1:0] aop, input logic [5:0] f, input logic [5:0] iop);
        logic [6:0] r;
        r = {3'b000, 4'b0010};
        if (aop == 2'b01) r = {3'b000, 4'b0110};
        else if (aop == 2'b10) begin
            case (f)
                6'd32: r = {3'b001, 4'b0010};
                6'd33: r = {3'b000, 4'b0010};
                6'd34: r = {3'b001, 4'b0110};
                6'd35: r = {3'b000, 4'b0110};
                6'd36: r = {3'b000, 4'b0000};
                6'd37: r = {3'b000, 4'b0001};
                6'd39: r = {3'b000, 4'b1100};
                6'd42: r = {3'b000, 4'b0111};
                default: r = {3'b010, 4'b0010};
            endcase
        end else if (aop == 2'b11) begin
            case (iop)
                6'd8:  r = {3'b001, 4'b0010};
                6'd9:  r = {3'b000, 4'b0010};
                6'd10: r = {3'b000, 4'b0111};
                6'd12: r = {3'b100, 4'b0000};
                6'd13: r = {3'b100, 4'b0001};
                default: r = {3'b010, 4'b0010};
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] base);
        logic [31:0] v;
        v = base;
`ifdef ALU_FWD_EN
        if (exmem_reg_write && exmem_rd == a && a != 5'd0) v = exmem_result;
        else if (mwb_reg_write && mwb_rd == a && a != 5'd0) v = mwb_result;
`endif
        return v;
    endfunction

    task automatic tick();
        exp_t e;
        logic [6:0] d;
        @(posedge clk);
        d = dec(alu_op, funct, i_opcode);
        if (rst || flush || (!stall && !in_valid)) begin
            model_r = '0;
        end else if (!stall) begin
            model_r.valid = 1'b1;
            model_r.opc   = d[3:0];
            model_r.dest  = reg_dst ? rd_addr : rt_addr;
            model_r.rs_a  = rs_addr;
            model_r.rt_a  = rt_addr;
            model_r.rs_d  = rs_data;
            model_r.rt_d  = rt_data;
            model_r.imm   = d[6] ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
            model_r.asrc  = alu_src;
            model_r.rw    = reg_write & ~d[5];
            model_r.mr    = mem_read;
            model_r.mw    = mem_write;
            model_r.m2r   = mem_to_reg;
            model_r.ovf   = d[4];
            model_r.ill   = d[5];
        end
        sb_q.push_back(model_r);
        #1;
        e = sb_q.pop_front();
        check_val("alu_a", alu_a, fwd(e.rs_a, e.rs_d));
        check_val("alu_b", alu_b, e.asrc ? e.imm : fwd(e.rt_a, e.rt_d));
        check_val("store_data", ex_store_data, fwd(e.rt_a, e.rt_d));
        check_val("alu_opcode", {28'd0, alu_opcode}, {28'd0, e.opc});
        check_val("ex_dest", {27'd0, ex_dest}, {27'd0, e.dest});
        check_val("ctrl", {25'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                           ex_mem_to_reg, ex_check_ovf, ex_illegal},
                  {25'd0, e.valid, e.rw, e.mr, e.mw, e.m2r, e.ovf, e.ill});
    endtask

    task automatic instr(input logic [1:0] aop, input logic [5:0] f, input logic [5:0] iop,
                         input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                         input logic asrc, input logic rdst);
        in_valid = 1'b1; alu_op = aop; funct = f; i_opcode = iop;
        rs_addr = rsa; rt_addr = rta; rd_addr = rda; rs_data = rsd; rt_data = rtd;
        imm16 = imm; alu_src = asrc; reg_dst = rdst;
        reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    endtask

    initial begin
        model_r = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        instr(2'b10, 6'd32, 6'd0, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 16'h1234, 1'b0, 1'b1);
        exmem_reg_write = 1'b0; mwb_reg_write = 1'b0; exmem_rd = 5'd0; mwb_rd = 5'd0;
        exmem_result = 32'h0; mwb_result = 32'h0;
        // Reset held for two cycles
        tick(); tick();
        check_val("rst_valid", {31'd0, ex_valid}, 32'd0);
        rst = 1'b0;

        // R-type sub 7-3
        instr(2'b10, 6'b100010, 6'd0, 5'd4, 5'd6, 5'd9, 32'd7, 32'd3, 16'h0000, 1'b0, 1'b1);
        tick();
        check_val("sub_opc", {28'd0, alu_opcode}, 32'h6);
        check_val("sub_a", alu_a, 32'd7);
        check_val("sub_b", alu_b, 32'd3);
        check_val("sub_dest", {27'd0, ex_dest}, 32'd9);

        // andi vs addi immediate extension
        instr(2'b11, 6'd0, 6'b001100, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'hFFFF, 1'b1, 1'b0);
        tick();
        check_val("andi_b", alu_b, 32'h0000FFFF);
        instr(2'b11, 6'd0, 6'b001000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'hFFFF, 1'b1, 1'b0);
        tick();
        check_val("addi_b", alu_b, 32'hFFFFFFFF);
        check_val("addi_dest", {27'd0, ex_dest}, 32'd2);

        // Forwarding priority and register-zero exclusion
        instr(2'b00, 6'd0, 6'd0, 5'd5, 5'd5, 5'd7, 32'h11, 32'h22, 16'h0004, 1'b1, 1'b1);
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
        mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'hBB;
        tick();
`ifdef ALU_FWD_EN
        check_val("fwd_exmem", alu_a, 32'hAA);
`else
        check_val("nofwd_a", alu_a, 32'h11);
`endif
        exmem_reg_write = 1'b0;
        tick();
        instr(2'b00, 6'd0, 6'd0, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 16'h0000, 1'b0, 1'b1);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; mwb_rd = 5'd0;
        tick();
        check_val("fwd_r0", alu_a, 32'h33);
        exmem_reg_write = 1'b0; mwb_reg_write = 1'b0;

        // Stall for three cycles with changing inputs, then flush during stall
        instr(2'b10, 6'b100101, 6'd0, 5'd8, 5'd9, 5'd10, 32'hF0, 32'h0F, 16'h0000, 1'b0, 1'b1);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr(2'b01, 6'd0, 6'd0, 5'(i + 11), 5'(i + 12), 5'(i + 13), 32'(i * 7), 32'(i * 9),
                  16'(i), 1'b1, 1'b0);
            tick();
            check_val("stall_hold_a", alu_a, 32'hF0);
        end
        flush = 1'b1;
        tick();
        check_val("stall_flush", {30'd0, ex_valid, ex_reg_write}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Illegal funct, then a legal instruction clears it; then a non-valid bubble
        instr(2'b10, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 16'h0000, 1'b0, 1'b1);
        tick();
        check_val("illegal", {29'd0, ex_illegal, ex_reg_write, ex_valid}, 32'b101);
        instr(2'b10, 6'b100100, 6'd0, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 16'h0000, 1'b0, 1'b1);
        tick();
        check_val("legal_after", {31'd0, ex_illegal}, 32'd0);
        in_valid = 1'b0;
        tick();

        // Randomised traffic through the same scoreboard
        for (int n = 0; n < 200; n++) begin
            instr(2'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32 + $urandom_range(0, 10)),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(8 + $urandom_range(0, 5)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                  $urandom, $urandom, 16'($urandom), 1'($urandom), 1'($urandom));
            reg_write = 1'($urandom); mem_read = 1'($urandom);
            mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
            in_valid = ($urandom_range(0, 7) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 31) == 0);
            exmem_reg_write = 1'($urandom); mwb_reg_write = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 3)); mwb_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom; mwb_result = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
